// File: rtl/aes_job_ctrl.sv
// aes_job_ctrl: single-job sequencer in front of an AES core.
// It accepts one request, pulses start to the core and waits for finish.
// If finish does not arrive within TIMEOUT_CYCLES cycles, the job is aborted.
// The result or timeout is then held as a response until the downstream side accepts it.
module aes_job_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_data,
    input  logic [127:0] req_key,
    input  logic         req_cipher,
    output logic         start,
    output logic [127:0] din,
    output logic [127:0] key_in,
    output logic         cipher,
    input  logic [127:0] dout,
    input  logic         finish,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_timeout,
    output logic         busy,
    output logic [15:0]  jobs_done,
    output logic [7:0]   timeouts
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    // Last WAIT-cycle count before the job is declared timed out
    localparam logic [15:0] TCNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]   state_q,       state_d;
    logic [15:0]  tcnt_q,        tcnt_d;
    logic [127:0] din_q,         din_d;
    logic [127:0] key_q,         key_d;
    logic         cipher_q,      cipher_d;
    logic [127:0] rsp_data_q,    rsp_data_d;
    logic         rsp_timeout_q, rsp_timeout_d;
    logic [15:0]  jobs_done_q,   jobs_done_d;
    logic [7:0]   timeouts_q,    timeouts_d;

    // Handshake and status outputs decoded from the current state
    always_comb begin
        req_ready = (state_q == IDLE) && !arst;
        start     = (state_q == START);
        rsp_valid = (state_q == RESP);
        busy      = (state_q != IDLE);
    end

    assign din         = din_q;
    assign key_in      = key_q;
    assign cipher      = cipher_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_timeout = rsp_timeout_q;
    assign jobs_done   = jobs_done_q;
    assign timeouts    = timeouts_q;

    // Next-state logic for the job FSM, datapath registers and counters
    always_comb begin
        state_d       = state_q;
        tcnt_d        = tcnt_q;
        din_d         = din_q;
        key_d         = key_q;
        cipher_d      = cipher_q;
        rsp_data_d    = rsp_data_q;
        rsp_timeout_d = rsp_timeout_q;
        jobs_done_d   = jobs_done_q;
        timeouts_d    = timeouts_q;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    din_d    = req_data;
                    key_d    = req_key;
                    cipher_d = req_cipher;
                    state_d  = START;
                end
            end
            START: begin
                tcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // finish takes priority over expiry in the same cycle
                if (finish) begin
                    rsp_data_d    = dout;
                    rsp_timeout_d = 1'b0;
                    state_d       = RESP;
                end else if (tcnt_q == TCNT_LAST) begin
                    rsp_data_d    = '0;
                    rsp_timeout_d = 1'b1;
                    if (timeouts_q != 8'hFF) begin
                        timeouts_d = timeouts_q + 8'd1;
                    end
                    state_d       = RESP;
                end else begin
                    tcnt_d = tcnt_q + 16'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    jobs_done_d = jobs_done_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (arst) begin
            state_q       <= IDLE;
            tcnt_q        <= '0;
            din_q         <= '0;
            key_q         <= '0;
            cipher_q      <= 1'b0;
            rsp_data_q    <= '0;
            rsp_timeout_q <= 1'b0;
            jobs_done_q   <= '0;
            timeouts_q    <= '0;
        end else begin
            state_q       <= state_d;
            tcnt_q        <= tcnt_d;
            din_q         <= din_d;
            key_q         <= key_d;
            cipher_q      <= cipher_d;
            rsp_data_q    <= rsp_data_d;
            rsp_timeout_q <= rsp_timeout_d;
            jobs_done_q   <= jobs_done_d;
            timeouts_q    <= timeouts_d;
        end
    end

endmodule

// File: doc/aes_job_ctrl.md
AES_JOB_CTRL -- requirements
Module: aes_job_ctrl

Interface
REQ-001 TIMEOUT_CYCLES, 64, WAIT-state cycles without finish before a job is aborted (range 2..65535).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 arst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  upstream job request valid.
REQ-005 req_ready  output  1  controller can accept a job.
REQ-006 req_data  input  128  plaintext or ciphertext block.
REQ-007 req_key  input  128  AES key.
REQ-008 req_cipher  input  1  1 = encrypt, 0 = decrypt.
REQ-009 start  output  1  one-cycle start pulse to AES core.
REQ-010 din  output  128  block to AES core.
REQ-011 key_in  output  128  key to AES core.
REQ-012 cipher  output  1  direction to AES core.
REQ-013 dout  input  128  AES core result.
REQ-014 finish  input  1  AES core completion pulse.
REQ-015 rsp_valid  output  1  response valid.
REQ-016 rsp_ready  input  1  downstream accepts response.
REQ-017 rsp_data  output  128  result, or 0 on timeout.
REQ-018 rsp_timeout  output  1  response was produced by timeout.
REQ-019 busy  output  1  state != IDLE.
REQ-020 jobs_done  output  16  count of completed responses (finish or timeout), wraps 0xFFFF->0.
REQ-021 timeouts  output  8  count of timed-out jobs, saturates at 0xFF.

Function
REQ-022 FSM states IDLE, START, WAIT, RESP shall be implemented; one job in flight maximum.
REQ-023 IDLE: req_ready=1; on req_valid&&req_ready, req_data/req_key/req_cipher registered into din/key_in/cipher, next state START.
REQ-024 START: start=1 for exactly one cycle, timeout counter cleared to 0, next state WAIT.
REQ-025 din/key_in/cipher shall hold stable from START through the last WAIT cycle.
REQ-026 WAIT: finish=1 -> rsp_data<=dout, rsp_timeout<=0, next RESP; else counter increments.
REQ-027 WAIT: counter==TIMEOUT_CYCLES-1 with finish=0 -> rsp_data<=0, rsp_timeout<=1, timeouts+1 (saturating), next RESP.
REQ-028 finish and timeout expiry in the same cycle: finish wins, no timeout recorded.
REQ-029 finish sampled in IDLE, START or RESP shall be ignored without state change.
REQ-030 RESP: rsp_valid=1, rsp_data/rsp_timeout stable until rsp_valid&&rsp_ready; on handshake jobs_done+1, next IDLE.
REQ-031 req_ready=0 in START, WAIT, RESP; req_valid there shall have no effect.
REQ-032 Latency: request accepted cycle N -> start high N+1 -> WAIT from N+2; finish at cycle F -> rsp_valid from F+1; with rsp_ready=1, req_ready high at F+2.
REQ-033 start shall never be asserted while busy with a previous job.

Reset
REQ-034 arst=1 at a rising edge: state IDLE; start, rsp_valid, rsp_timeout, busy = 0; din, key_in, rsp_data = 0; cipher = 0; counters and timeout counter = 0.
REQ-035 req_ready shall be 0 during any cycle with arst=1, and 1 in the first cycle after arst deasserts.
REQ-036 Reset mid-job shall abandon the job: no response issued, start low from the next cycle, later finish ignored.

Verification
REQ-037 Encrypt: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff, cipher=1, model finishes 10 cycles after start with dout 69c4e0d86a7b0430d8cdb78070b4c55a -> rsp_data equals it, rsp_timeout=0, jobs_done=1.
REQ-038 Decrypt same key, data 69c4e0d86a7b0430d8cdb78070b4c55a, cipher=0 -> cipher low during start, rsp_data 00112233445566778899aabbccddeeff.
REQ-039 TIMEOUT_CYCLES=8, finish never asserted -> rsp_valid exactly 8 cycles after start cycle+1, rsp_data=0, rsp_timeout=1, timeouts=1.
REQ-040 finish on the expiry cycle (TIMEOUT_CYCLES=8) -> rsp_timeout=0, rsp_data=dout, timeouts unchanged.
REQ-041 rsp_ready held low 20 cycles, req_valid high throughout -> rsp_data stable, req_ready=0, no second start; release -> next job accepted one cycle after handshake.
REQ-042 arst pulsed 3 cycles into WAIT, then stray finish -> no rsp_valid, counters 0, state IDLE, req_ready=1 after reset.
